// File: rtl/bus_transfer_controller.sv
// bus_transfer_controller
//   Sequences register-to-register moves over the shared bidirectional bus.
//   For each accepted request it drives one-hot ENABLE/RW/COUNT strobes
//   to NUM_REGS bus registers: a source drives the bus while a destination
//   latches it, optionally followed by a post-increment of the source.
//
//   Optional feature macro: BUS_TURNAROUND_EN
//     defined     : MOVE/MOVE_INC spend one dead-bus cycle (TURN) before XFER
//     not defined : IDLE goes straight to XFER
module bus_transfer_controller #(
    parameter int NUM_REGS  = 8,
    parameter int SEL_WIDTH = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [1:0]           req_op_i,
    input  logic [SEL_WIDTH-1:0] req_src_i,
    input  logic [SEL_WIDTH-1:0] req_dst_i,
    output logic [NUM_REGS-1:0]  reg_enable_o,
    output logic [NUM_REGS-1:0]  reg_rw_o,
    output logic [NUM_REGS-1:0]  reg_count_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);

    localparam logic [1:0] OP_MOVE     = 2'b00;
    localparam logic [1:0] OP_MOVE_INC = 2'b01;
    localparam logic [1:0] OP_INC      = 2'b10;
    localparam logic [1:0] OP_RSVD     = 2'b11;

    localparam logic [NUM_REGS-1:0] ONE_HOT0 = NUM_REGS'(1);

`ifdef BUS_TURNAROUND_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TURN = 3'd1,
        S_XFER = 3'd2,
        S_INC  = 3'd3,
        S_FIN  = 3'd4
    } state_e;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_XFER = 3'd2,
        S_INC  = 3'd3,
        S_FIN  = 3'd4
    } state_e;
`endif

    state_e               state_q, state_d;
    logic [1:0]           op_q;
    logic [SEL_WIDTH-1:0] src_q;
    logic [SEL_WIDTH-1:0] dst_q;
    logic                 err_q;

    logic                 accept;
    logic                 src_oob;
    logic                 dst_oob;
    logic                 req_bad;
    logic [NUM_REGS-1:0]  src_oh;
    logic [NUM_REGS-1:0]  dst_oh;

    // Request legality: reserved op, out-of-range selects, or a move onto itself.
    always_comb begin
        src_oob = 32'(req_src_i) >= 32'(NUM_REGS);
        dst_oob = 32'(req_dst_i) >= 32'(NUM_REGS);
        req_bad = (req_op_i == OP_RSVD) || src_oob ||
                  ((req_op_i != OP_INC) && (dst_oob || (req_src_i == req_dst_i)));
    end

    assign accept = req_valid_i && req_ready_o;

    // One-hot selects come only from captured fields, so mid-operation changes
    // on the request port never reach the strobes.
    assign src_oh = ONE_HOT0 << src_q;
    assign dst_oh = ONE_HOT0 << dst_q;

    // State register; async reset aborts any transfer in progress.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the request fields and its verdict at the accept edge only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q  <= OP_MOVE;
            src_q <= '0;
            dst_q <= '0;
            err_q <= 1'b0;
        end else if (accept) begin
            op_q  <= req_op_i;
            src_q <= req_src_i;
            dst_q <= req_dst_i;
            err_q <= req_bad;
        end
    end

    // Next-state and output decode; outputs depend on registered state only.
    always_comb begin
        state_d      = state_q;
        req_ready_o  = 1'b0;
        reg_enable_o = '0;
        reg_rw_o     = '0;
        reg_count_o  = '0;
        busy_o       = 1'b1;
        done_o       = 1'b0;
        err_o        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (req_valid_i) begin
                    if (req_bad) begin
                        state_d = S_FIN;
                    end else if (req_op_i == OP_INC) begin
                        state_d = S_INC;
                    end else begin
`ifdef BUS_TURNAROUND_EN
                        state_d = S_TURN;
`else
                        state_d = S_XFER;
`endif
                    end
                end
            end
`ifdef BUS_TURNAROUND_EN
            S_TURN: begin
                // Dead bus cycle: nobody drives, nobody latches.
                state_d = S_XFER;
            end
`endif
            S_XFER: begin
                // Source drives the bus, destination latches it at the edge.
                reg_enable_o = src_oh | dst_oh;
                reg_rw_o     = src_oh;
                state_d      = (op_q == OP_MOVE_INC) ? S_INC : S_FIN;
            end
            S_INC: begin
                // Counting requires RW=1 with ENABLE low so the source stays off the bus.
                reg_rw_o    = src_oh;
                reg_count_o = src_oh;
                state_d     = S_FIN;
            end
            S_FIN: begin
                done_o  = 1'b1;
                err_o   = err_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_transfer_controller.sv
// Self-checking bench for bus_transfer_controller.
// Expected behaviour comes from a request-level model that expands each
// request into its list of per-cycle outputs from the latency rules.
module tb_bus_transfer_controller;

`ifdef BUS_TURNAROUND_EN
    localparam int TURN = 1;
`else
    localparam int TURN = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [2:0] req_src;
    logic [2:0] req_dst;
    logic [7:0] reg_enable;
    logic [7:0] reg_rw;
    logic [7:0] reg_count;
    logic       busy;
    logic       done;
    logic       err;

    bus_transfer_controller #(.NUM_REGS(8), .SEL_WIDTH(3)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_op_i    (req_op),
        .req_src_i   (req_src),
        .req_dst_i   (req_dst),
        .reg_enable_o(reg_enable),
        .reg_rw_o    (reg_rw),
        .reg_count_o (reg_count),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       ready;
        logic [7:0] enable;
        logic [7:0] rw;
        logic [7:0] count;
        logic       busy;
        logic       done;
        logic       err;
    } out_t;

    typedef struct {
        logic [1:0] op;
        logic [2:0] src;
        logic [2:0] dst;
        logic       err;
        int         lat;      // DONE cycle, without turnaround
        logic [7:0] en;       // first cycle with any strobe active
        logic [7:0] rw;
        logic [7:0] cnt;
    } vec_t;

    int   n_chk = 0;
    int   n_err = 0;
    out_t exp_q[$];
    out_t IDLE_OUT;

    function automatic out_t sample();
        out_t o;
        o.ready  = req_ready;
        o.enable = reg_enable;
        o.rw     = reg_rw;
        o.count  = reg_count;
        o.busy   = busy;
        o.done   = done;
        o.err    = err;
        return o;
    endfunction

    task automatic check_out(input string name, input out_t act, input out_t exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got rdy=%b en=%h rw=%h cnt=%h busy=%b done=%b err=%b, want rdy=%b en=%h rw=%h cnt=%h busy=%b done=%b err=%b",
                     name, act.ready, act.enable, act.rw, act.count, act.busy, act.done, act.err,
                     exp.ready, exp.enable, exp.rw, exp.count, exp.busy, exp.done, exp.err);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Request-level model: appends the outputs seen on cycles c1..cN after accept.
    function automatic void model(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst);
        out_t o;
        bit   is_move = (op == 2'd0) || (op == 2'd1);
        bit   bad = (op == 2'd3) || (int'(src) >= 8) ||
                    (is_move && ((int'(dst) >= 8) || (src == dst)));
        o = '0;
        o.busy = 1'b1;
        if (bad) begin
            o.done = 1'b1;
            o.err  = 1'b1;
            exp_q.push_back(o);
            return;
        end
        if (is_move) begin
            if (TURN == 1) exp_q.push_back(o);
            o.enable = (8'd1 << src) | (8'd1 << dst);
            o.rw     = 8'd1 << src;
            exp_q.push_back(o);
            o.enable = '0;
        end
        if (op != 2'd0) begin
            o.rw    = 8'd1 << src;
            o.count = 8'd1 << src;
            exp_q.push_back(o);
        end
        o       = '0;
        o.busy  = 1'b1;
        o.done  = 1'b1;
        exp_q.push_back(o);
    endfunction

    // Issue one request from an IDLE negedge and compare every cycle to the model.
    // Returns at the negedge of the DONE cycle.
    task automatic run_req(input string name, input logic [1:0] op, input logic [2:0] src,
                           input logic [2:0] dst, input bit noise,
                           output int done_cyc, output logic done_err, output out_t first_act);
        out_t act;
        int   n;
        exp_q.delete();
        model(op, src, dst);
        n = exp_q.size();
        @(negedge clk);
        check_out({name, "_idle"}, sample(), IDLE_OUT);
        req_valid = 1'b1;
        req_op    = op;
        req_src   = src;
        req_dst   = dst;
        done_cyc  = -1;
        done_err  = 1'b0;
        first_act = '0;
        @(posedge clk);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            act = sample();
            if (noise) begin
                req_valid = 1'($urandom);
                req_op    = 2'($urandom);
                req_src   = 3'($urandom);
                req_dst   = 3'($urandom);
            end else begin
                req_valid = 1'b0;
            end
            check_out($sformatf("%s_c%0d", name, c), act, exp_q[c-1]);
            if (act.done && done_cyc < 0) begin
                done_cyc = c;
                done_err = act.err;
            end
            if ((act.enable | act.count) != 0 && first_act == '0) first_act = act;
        end
    endtask

    vec_t vecs[$];
    int   dc;
    logic de;
    out_t fa;
    out_t act;
    int   lat;

    initial begin
        IDLE_OUT = '0;
        IDLE_OUT.ready = 1'b1;

        vecs.push_back('{2'd0, 3'd2, 3'd5, 1'b0, 2, 8'h24, 8'h04, 8'h00});
        vecs.push_back('{2'd1, 3'd0, 3'd7, 1'b0, 3, 8'h81, 8'h01, 8'h00});
        vecs.push_back('{2'd2, 3'd6, 3'd1, 1'b0, 2, 8'h00, 8'h40, 8'h40});
        vecs.push_back('{2'd2, 3'd3, 3'd3, 1'b0, 2, 8'h00, 8'h08, 8'h08});
        vecs.push_back('{2'd0, 3'd3, 3'd3, 1'b1, 1, 8'h00, 8'h00, 8'h00});
        vecs.push_back('{2'd3, 3'd1, 3'd2, 1'b1, 1, 8'h00, 8'h00, 8'h00});
        vecs.push_back('{2'd1, 3'd4, 3'd4, 1'b1, 1, 8'h00, 8'h00, 8'h00});
        vecs.push_back('{2'd0, 3'd7, 3'd0, 1'b0, 2, 8'h81, 8'h80, 8'h00});
        vecs.push_back('{2'd0, 3'd1, 3'd4, 1'b0, 2, 8'h12, 8'h02, 8'h00});

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_src   = 3'd0;
        req_dst   = 3'd0;
        #3;
        check_out("reset_state", sample(), IDLE_OUT);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven directed vectors.
        foreach (vecs[i]) begin
            run_req($sformatf("vec%0d", i), vecs[i].op, vecs[i].src, vecs[i].dst, 1'b0, dc, de, fa);
            lat = vecs[i].lat + ((!vecs[i].err && vecs[i].op != 2'd2) ? TURN : 0);
            check_val($sformatf("vec%0d_latency", i), dc, lat);
            check_val($sformatf("vec%0d_err", i), int'(de), int'(vecs[i].err));
            check_val($sformatf("vec%0d_en", i), int'(fa.enable), int'(vecs[i].en));
            check_val($sformatf("vec%0d_rw", i), int'(fa.rw), int'(vecs[i].rw));
            check_val($sformatf("vec%0d_cnt", i), int'(fa.count), int'(vecs[i].cnt));
        end

        // Reset asserted while the transfer strobes are active.
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'd0; req_src = 3'd2; req_dst = 3'd5;
        @(posedge clk);
        for (int c = 0; c < 1 + TURN; c++) @(negedge clk);
        req_valid = 1'b0;
        check_val("rst_pre_xfer_en", int'(reg_enable), 'h24);
        #2 rst_n = 1'b0;
        #1 check_out("rst_mid_xfer", sample(), IDLE_OUT);
        @(negedge clk);
        check_out("rst_held", sample(), IDLE_OUT);
        rst_n = 1'b1;

        // Back-to-back MOVEs with VALID held: second accepted the cycle after DONE.
        exp_q.delete();
        model(2'd0, 3'd2, 3'd5);
        exp_q.push_back(IDLE_OUT);
        model(2'd0, 3'd1, 3'd6);
        exp_q.push_back(IDLE_OUT);
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'd0; req_src = 3'd2; req_dst = 3'd5;
        @(posedge clk);
        for (int c = 0; c < exp_q.size(); c++) begin
            @(negedge clk);
            act = sample();
            req_src = 3'd1; req_dst = 3'd6;
            if (c == exp_q.size() - 2) req_valid = 1'b0;
            check_out($sformatf("b2b_c%0d", c + 1), act, exp_q[c]);
        end
        req_valid = 1'b0;

        // Randomized requests with garbage on the request port while busy.
        for (int k = 0; k < 60; k++) begin
            run_req($sformatf("rnd%0d", k), 2'($urandom), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 1'b1, dc, de, fa);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
